// File: rtl/xmt_cfg.sv
//============================================================================
// xmt_cfg : configurable serial transmitter (width/parity/stop/baud divisor)
//           with a one-character holding register and line-break control.
// Rev 1.0
//============================================================================
`default_nettype none

module xmt_cfg #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic                 brk,
   input  logic                 load,
   input  logic [DATA_BITS-1:0] parallel_in,
   output logic                 empty,
   output logic                 busy,
   output logic                 serial_out
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_PAR   = 3'd3,
      S_STOP  = 3'd4
   } state_t;

   localparam int                   c_BW      = 4;
   localparam logic                 c_ODD     = (PARITY == 2);
   localparam logic [c_BW-1:0]      c_BIT_ONE = c_BW'(1);
   localparam logic [c_BW-1:0]      c_LAST_D  = c_BW'(DATA_BITS - 1);
   localparam logic [c_BW-1:0]      c_LAST_S  = c_BW'(STOP_BITS - 1);
   localparam logic [DIV_WIDTH-1:0] c_CNT_ONE = DIV_WIDTH'(1);

   state_t                 r_state;
   logic [DATA_BITS-1:0]   r_shift;
   logic [DATA_BITS-1:0]   r_hold;
   logic                   r_full;
   logic                   r_par;
   logic [DIV_WIDTH-1:0]   r_div;
   logic [DIV_WIDTH-1:0]   r_cnt;
   logic [c_BW-1:0]        r_bit;
   logic                   r_so;
   logic                   r_busy;

   logic                   w_tick;
   logic                   w_last_stop;
   logic                   w_hold_rd;
   logic                   w_direct;
   logic                   w_start;
   logic                   w_hold_wr;
   logic                   w_end_idle;
   logic                   w_idle_nxt;
   logic                   w_full_nxt;
   logic [DATA_BITS-1:0]   w_char;

   // Frame sequencing decisions shared by the state register and the busy flag.
   assign w_tick      = (r_cnt == '0);
   assign w_last_stop = (r_state == S_STOP) & w_tick & (r_bit == c_LAST_S);
   assign w_hold_rd   = r_full & ~brk & ((r_state == S_IDLE) | w_last_stop);
   assign w_direct    = (r_state == S_IDLE) & ~brk & load & ~r_full;
   assign w_start     = w_hold_rd | w_direct;
   assign w_hold_wr   = load & ~r_full & ~w_direct;
   assign w_end_idle  = w_last_stop & ~w_hold_rd;
   assign w_idle_nxt  = w_end_idle | ((r_state == S_IDLE) & ~w_start);
   assign w_full_nxt  = (r_full & ~w_hold_rd) | w_hold_wr;
   assign w_char      = w_hold_rd ? r_hold : parallel_in;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_hold  <= '0;
         r_full  <= 1'b0;
         r_par   <= 1'b0;
         r_div   <= '0;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_so    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_busy <= ~w_idle_nxt | w_full_nxt;
         r_full <= w_full_nxt;
         if (w_hold_wr)
            r_hold <= parallel_in;

         if (w_start) begin
            r_state <= S_START;
            r_shift <= w_char;
            r_par   <= (^w_char) ^ c_ODD;
            r_div   <= div;
            r_cnt   <= div;
            r_bit   <= '0;
            r_so    <= 1'b0;
         end else if (r_state == S_IDLE) begin
            r_so <= ~brk;
         end else if (!w_tick) begin
            r_cnt <= r_cnt - c_CNT_ONE;
         end else begin
            r_cnt <= r_div;
            case (r_state)
               S_START: begin
                  r_state <= S_DATA;
                  r_so    <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_bit   <= '0;
               end
               S_DATA: begin
                  if (r_bit == c_LAST_D) begin
                     r_bit <= '0;
                     if (PARITY != 0) begin
                        r_state <= S_PAR;
                        r_so    <= r_par;
                     end else begin
                        r_state <= S_STOP;
                        r_so    <= 1'b1;
                     end
                  end else begin
                     r_bit   <= r_bit + c_BIT_ONE;
                     r_so    <= r_shift[0];
                     r_shift <= r_shift >> 1;
                  end
               end
               S_PAR: begin
                  r_state <= S_STOP;
                  r_so    <= 1'b1;
                  r_bit   <= '0;
               end
               S_STOP: begin
                  if (w_end_idle) begin
                     r_state <= S_IDLE;
                     r_so    <= 1'b1;
                  end else begin
                     r_bit <= r_bit + c_BIT_ONE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign empty      = ~r_full;
   assign busy       = r_busy;
   assign serial_out = r_so;

endmodule

`default_nettype wire

// File: tb/tb_xmt_cfg.sv
//============================================================================
// tb_xmt_cfg : directed bench for xmt_cfg in three parameter configurations.
// Rev 1.0
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_xmt_cfg;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] dv;
   logic        brk;
   logic        ld [3];
   logic [8:0]  din;
   logic        so [3];
   logic        emp [3];
   logic        bsy [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // u0: 8N1, u1: 7 data / even / 2 stop, u2: 7 data / odd / 1 stop
   xmt_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_WIDTH(16)) u0 (
      .clk(clk), .reset(reset), .div(dv), .brk(brk), .load(ld[0]),
      .parallel_in(din[7:0]), .empty(emp[0]), .busy(bsy[0]), .serial_out(so[0]));
   xmt_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DIV_WIDTH(16)) u1 (
      .clk(clk), .reset(reset), .div(dv), .brk(brk), .load(ld[1]),
      .parallel_in(din[6:0]), .empty(emp[1]), .busy(bsy[1]), .serial_out(so[1]));
   xmt_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .DIV_WIDTH(16)) u2 (
      .clk(clk), .reset(reset), .div(dv), .brk(brk), .load(ld[2]),
      .parallel_in(din[6:0]), .empty(emp[2]), .busy(bsy[2]), .serial_out(so[2]));

   typedef struct {
      int          d;
      logic [15:0] dv;
      logic [8:0]  data;
      logic [31:0] seq;   // transmitted order, first bit at position n-1
      int          n;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
      end
   endtask

   // Entered at the first sample point after the start edge.
   task automatic run_frame(input int d, input int dvv, input logic [31:0] seq,
                            input int n, input string nm);
      logic bad;
      logic a_so;
      logic a_bsy;
      for (int k = 0; k < n; k++) begin
         bad   = 1'b0;
         a_so  = seq[n-1-k];
         a_bsy = 1'b1;
         for (int c = 0; c <= dvv; c++) begin
            if (so[d] !== seq[n-1-k] || bsy[d] !== 1'b1) begin
               bad   = 1'b1;
               a_so  = so[d];
               a_bsy = bsy[d];
            end
            @(negedge clk);
         end
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL %s bit%0d actual line=%0b busy=%0b expected line=%0b busy=1",
                     nm, k, a_so, a_bsy, seq[n-1-k]);
         end
      end
      chk($sformatf("%s idle line", nm), so[d], 1'b1);
      chk($sformatf("%s idle busy", nm), bsy[d], 1'b0);
      chk($sformatf("%s idle empty", nm), emp[d], 1'b1);
   endtask

   // Two frames back to back through the holding register; a third load is dropped.
   task automatic b2b(input int d, input int dvv, input logic [8:0] a, input logic [8:0] b,
                      input logic [31:0] seq, input int n, input string nm);
      int total;
      int half;
      total = n * (dvv + 1);
      half  = (n / 2) * (dvv + 1);
      dv    = 16'(dvv);
      din   = a;
      ld[d] = 1'b1;
      @(negedge clk);
      for (int t = 0; t < total; t++) begin
         chk($sformatf("%s line t%0d", nm, t), so[d], seq[n-1-(t/(dvv+1))]);
         chk($sformatf("%s empty t%0d", nm, t), emp[d], (t >= 1 && t < half) ? 1'b0 : 1'b1);
         chk($sformatf("%s busy t%0d", nm, t), bsy[d], 1'b1);
         if (t == 0) din = b;
         if (t == 1) din = 9'h1AA;
         if (t == 2) ld[d] = 1'b0;
         @(negedge clk);
      end
      chk($sformatf("%s idle line", nm), so[d], 1'b1);
      chk($sformatf("%s idle busy", nm), bsy[d], 1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] s1;
      logic [9:0] s2;

      vt[0] = '{0, 16'd3, 9'h0A5, 32'b0101001011,  10};
      vt[1] = '{0, 16'd0, 9'h000, 32'b0000000001,  10};
      vt[2] = '{0, 16'd2, 9'h0FF, 32'b0111111111,  10};
      vt[3] = '{0, 16'd1, 9'h03C, 32'b0001111001,  10};
      vt[4] = '{0, 16'd0, 9'h001, 32'b0100000001,  10};
      vt[5] = '{1, 16'd1, 9'h003, 32'b01100000011, 11};
      vt[6] = '{2, 16'd1, 9'h003, 32'b0110000011,  10};
      vt[7] = '{1, 16'd0, 9'h007, 32'b01110000111, 11};
      vt[8] = '{2, 16'd2, 9'h07F, 32'b0111111101,  10};

      reset = 1'b0;
      brk   = 1'b0;
      din   = '0;
      dv    = 16'd3;
      for (int i = 0; i < 3; i++) ld[i] = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset line u%0d", i), so[i], 1'b1);
         chk($sformatf("reset empty u%0d", i), emp[i], 1'b1);
         chk($sformatf("reset busy u%0d", i), bsy[i], 1'b0);
      end
      reset = 1'b1;
      @(negedge clk);

      // Single frames from IDLE
      for (int i = 0; i < 9; i++) begin
         dv        = vt[i].dv;
         din       = vt[i].data;
         ld[vt[i].d] = 1'b1;
         @(negedge clk);
         ld[vt[i].d] = 1'b0;
         chk($sformatf("vec%0d empty after direct load", i), emp[vt[i].d], 1'b1);
         run_frame(vt[i].d, int'(vt[i].dv), vt[i].seq, vt[i].n, $sformatf("vec%0d", i));
         @(negedge clk);
      end

      // Back-to-back via holding register
      b2b(0, 1, 9'h055, 9'h00F, 32'b0101010101_0111100001, 20, "b2b8n1");
      @(negedge clk);
      b2b(1, 0, 9'h003, 9'h000, 32'b01100000011_00000000011, 22, "b2b7e2");
      @(negedge clk);

      // Break handling
      dv  = 16'd1;
      brk = 1'b1;
      @(negedge clk);
      chk("brk line low", so[0], 1'b0);
      chk("brk busy", bsy[0], 1'b0);
      chk("brk empty", emp[0], 1'b1);
      din   = 9'h041;
      ld[0] = 1'b1;
      @(negedge clk);
      ld[0] = 1'b0;
      chk("brk load empty", emp[0], 1'b0);
      chk("brk load busy", bsy[0], 1'b1);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("brk hold line c%0d", i), so[0], 1'b0);
         @(negedge clk);
      end
      chk("brk still held", emp[0], 1'b0);
      brk = 1'b0;
      @(negedge clk);
      chk("brk release empty", emp[0], 1'b1);
      run_frame(0, 1, 32'b0100000101, 10, "brkframe");
      brk = 1'b1;
      @(negedge clk);
      chk("brk2 line low", so[0], 1'b0);
      brk = 1'b0;
      @(negedge clk);
      chk("brk2 release line", so[0], 1'b1);
      @(negedge clk);

      // Asynchronous reset mid-frame with holding full
      dv    = 16'd3;
      din   = 9'h0A5;
      ld[0] = 1'b1;
      @(negedge clk);
      din   = 9'h00F;
      @(negedge clk);
      ld[0] = 1'b0;
      chk("rst pre empty", emp[0], 1'b0);
      repeat (8) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rst async line", so[0], 1'b1);
      chk("rst async empty", emp[0], 1'b1);
      chk("rst async busy", bsy[0], 1'b0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         chk($sformatf("post-rst idle c%0d", i), so[0], 1'b1);
      end
      chk("post-rst busy", bsy[0], 1'b0);

      // Divisor change mid-frame takes effect on the next frame
      s1    = 10'b0111100001;
      s2    = 10'b0000011111;
      dv    = 16'd3;
      din   = 9'h00F;
      ld[0] = 1'b1;
      @(negedge clk);
      for (int t = 0; t < 120; t++) begin
         chk($sformatf("divchg line t%0d", t), so[0],
             (t < 40) ? s1[9 - t/4] : s2[9 - (t-40)/8]);
         if (t == 0)  din = 9'h0F0;
         if (t == 1)  ld[0] = 1'b0;
         if (t == 10) dv = 16'd7;
         @(negedge clk);
      end
      chk("divchg idle line", so[0], 1'b1);
      chk("divchg idle busy", bsy[0], 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
